lane_renderer: RTL

Draws one game lane into the VGA frame buffer. On each `start` pulse it snapshots the visible portion of the lane shift register and sweeps a rectangular column of pixels through the `vga_adapter` write port (`x`, `y`, `colour`, `plot`), one pixel per clock. Note slots are drawn in `NOTE_COLOUR` and empty slots in `BG_COLOUR`. It sits between the game datapath, which supplies `lane` and a per-shift `start` pulse, and the single `vga_adapter` instance.

---
 rtl/lane_renderer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/lane_renderer.sv
// Sweeps one game lane column into the vga_adapter write port, one pixel per clock.
// Optional hit-bar row enabled by defining LANE_RENDERER_HITBAR_EN.
module lane_renderer #(
    parameter int         VISIBLE     = 20,
    parameter int         NOTE_W      = 8,
    parameter int         NOTE_H      = 4,
    parameter int         X0          = 40,
    parameter int         Y0          = 0,
    parameter logic [2:0] NOTE_COLOUR = 3'b010,
    parameter logic [2:0] BG_COLOUR   = 3'b000,
    parameter logic [2:0] HIT_COLOUR  = 3'b100
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [VISIBLE-1:0] lane_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [7:0]         x_o,
    output logic [6:0]         y_o,
    output logic [2:0]         colour_o,
    output logic               plot_o
);

`ifdef LANE_RENDERER_HITBAR_EN
    localparam int HB = 1;
`else
    localparam int HB = 0;
`endif

    localparam int ROWS   = VISIBLE * NOTE_H;
    localparam int ROWS_T = ROWS + HB;
    localparam int COL_W  = (NOTE_W > 1) ? $clog2(NOTE_W) : 1;
    localparam int ROW_W  = (ROWS_T > 1) ? $clog2(ROWS_T) : 1;
    localparam int SLOT_W = (VISIBLE > 1) ? $clog2(VISIBLE) : 1;
    localparam int XS_W   = (COL_W + 1 > 8) ? COL_W + 1 : 8;
    localparam int YS_W   = (ROW_W + 1 > 7) ? ROW_W + 1 : 7;

    if (X0 + NOTE_W > 160) begin : g_x_range
        $error("lane_renderer: lane does not fit in 160 columns");
    end
    if (Y0 + ROWS + HB > 120) begin : g_y_range
        $error("lane_renderer: lane does not fit in 120 rows");
    end

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

    state_t             state_q;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [VISIBLE-1:0] snap_q;
    logic [7:0]         x_q;
    logic [6:0]         y_q;
    logic [2:0]         colour_q;
    logic               plot_q, busy_q, done_q;
    logic               last_col, last_row;

    function automatic logic [7:0] x_at(input logic [COL_W-1:0] col);
        logic [XS_W-1:0] sum;
        sum = XS_W'(X0) + XS_W'(col);
        return sum[7:0];
    endfunction

    function automatic logic [6:0] y_at(input logic [ROW_W-1:0] row);
        logic [YS_W-1:0] sum;
        sum = YS_W'(Y0) + YS_W'(row);
        return sum[6:0];
    endfunction

    // Row 0 is the top of the lane, i.e. the slot furthest from the hit line.
    function automatic logic [2:0] colour_at(input logic [VISIBLE-1:0] snap,
                                             input logic [ROW_W-1:0]   row);
        logic [SLOT_W-1:0] slot;
        if (HB != 0 && int'(row) >= ROWS) return HIT_COLOUR;
        slot = SLOT_W'(VISIBLE - 1 - int'(row) / NOTE_H);
        return snap[slot] ? NOTE_COLOUR : BG_COLOUR;
    endfunction

    always_comb begin
        last_col = (col_q == COL_W'(NOTE_W - 1));
        last_row = (row_q == ROW_W'(ROWS_T - 1));
        col_d    = last_col ? '0 : col_q + 1'b1;
        row_d    = last_col ? row_q + 1'b1 : row_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            snap_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    plot_q <= 1'b0;
                    busy_q <= 1'b0;
                    state_q <= S_IDLE;
                    if (start_i) begin
                        snap_q   <= lane_i;
                        col_q    <= '0;
                        row_q    <= '0;
                        x_q      <= x_at('0);
                        y_q      <= y_at('0);
                        colour_q <= colour_at(lane_i, '0);
                        plot_q   <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (last_col && last_row) begin
                        plot_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        col_q    <= col_d;
                        row_q    <= row_d;
                        x_q      <= x_at(col_d);
                        y_q      <= y_at(row_d);
                        colour_q <= colour_at(snap_q, row_d);
                    end
                end
                default: begin
                    plot_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign x_o      = x_q;
    assign y_o      = y_q;
    assign colour_o = colour_q;
    assign plot_o   = plot_q;

endmodule
